// File: rtl/teclado_barrido.sv
// teclado_barrido: 4x4 keypad scanner with sync, press/release debounce and valid/ack capture
module teclado_barrido #(
   parameter int DIV_SCAN = 50000,
   parameter int DEB_CYC  = 500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] fil_in,
   output logic [3:0] col_out,
   output logic [3:0] fil,
   output logic [3:0] col,
   output logic       valid,
   input  logic       ack
);
   localparam int SW = DIV_SCAN > 1 ? $clog2(DIV_SCAN) : 1;
   localparam int DW = DEB_CYC > 1 ? $clog2(DEB_CYC) : 1;
   localparam logic [1:0] SCAN = 2'd0, DEB = 2'd1, HELD = 2'd2;
   logic [3:0] s1, fil_s, cand_fil, cand_col, col_rot;
   logic [1:0] state;
   logic [SW-1:0] scnt;
   logic [DW-1:0] dcnt;
   logic onehot, scan_end, deb_end, capture;
   // decode helpers: single-row detect, counter terminal counts, next column
   always_comb begin
      onehot   = fil_s != 4'd0 && (fil_s & (fil_s - 4'd1)) == 4'd0;
      scan_end = scnt == SW'(DIV_SCAN - 1);
      deb_end  = dcnt == DW'(DEB_CYC - 1);
      col_rot  = {col_out[0], col_out[3:1]};
      capture  = state == DEB && fil_s == cand_fil && deb_end && !valid;
   end
   // two-flop synchroniser for the asynchronous row lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1    <= 4'd0;
         fil_s <= 4'd0;
      end else begin
         s1    <= fil_in;
         fil_s <= s1;
      end
   end
   // scan / debounce / held-until-release sequencer; one counter serves press and release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= SCAN;
         scnt     <= '0;
         dcnt     <= '0;
         col_out  <= 4'b1000;
         cand_fil <= 4'd0;
         cand_col <= 4'd0;
      end else begin
         case (state)
            SCAN: begin
               if (scan_end) begin
                  scnt <= '0;
                  if (onehot) begin
                     state    <= DEB;
                     cand_fil <= fil_s;
                     cand_col <= col_out;
                  end else col_out <= col_rot;
               end else scnt <= scnt + SW'(1);
            end
            DEB: begin
               if (fil_s != cand_fil) begin
                  state   <= SCAN;
                  col_out <= col_rot;
                  dcnt    <= '0;
                  scnt    <= '0;
               end else if (deb_end) begin
                  state <= HELD;
                  dcnt  <= '0;
               end else dcnt <= dcnt + DW'(1);
            end
            HELD: begin
               if (fil_s != 4'd0) dcnt <= '0;
               else if (deb_end) begin
                  state   <= SCAN;
                  col_out <= col_rot;
                  dcnt    <= '0;
                  scnt    <= '0;
               end else dcnt <= dcnt + DW'(1);
            end
            default: state <= SCAN;
         endcase
      end
   end
   // output register and handshake; a capture only happens with valid low so it outranks ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fil   <= 4'd0;
         col   <= 4'd0;
         valid <= 1'b0;
      end else if (capture) begin
         fil   <= cand_fil;
         col   <= cand_col;
         valid <= 1'b1;
      end else if (ack && valid) valid <= 1'b0;
   end
endmodule

// File: tb/tb_teclado_barrido.sv
// tb_teclado_barrido: directed scenarios for the keypad scanner with a column-gated keypad model
module tb_teclado_barrido;
   logic clk = 1'b0, rst_n = 1'b0, ack = 1'b0;
   logic [3:0] fil_in, col_out, fil, col;
   logic valid;
   logic key_on = 1'b0;
   logic [3:0] key_row = 4'd0, key_col = 4'd0;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   assign fil_in = (key_on && col_out == key_col) ? key_row : 4'b0000;

   teclado_barrido #(.DIV_SCAN(4), .DEB_CYC(8)) dut (
      .clk(clk), .rst_n(rst_n), .fil_in(fil_in), .col_out(col_out),
      .fil(fil), .col(col), .valid(valid), .ack(ack)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      step(1);
      checks++; if (col_out !== 4'b1000) begin errors++; $display("FAIL reset_col_out got %b want 1000", col_out); end
      checks++; if (fil !== 4'b0000) begin errors++; $display("FAIL reset_fil got %b want 0000", fil); end
      checks++; if (col !== 4'b0000) begin errors++; $display("FAIL reset_col got %b want 0000", col); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
   endtask

   task automatic test_scan_rotation;
      logic [3:0] exp;
      key_on = 1'b0;
      do_reset;
      for (int k = 0; k <= 16; k++) begin
         exp = 4'b1000 >> ((k / 4) % 4);
         checks++; if (col_out !== exp) begin errors++; $display("FAIL scan_col_out k=%0d got %b want %b", k, col_out, exp); end
         checks++; if (valid !== 1'b0) begin errors++; $display("FAIL scan_valid k=%0d got %b want 0", k, valid); end
         step(1);
      end
   endtask

   task automatic test_press_ack;
      key_row = 4'b0010; key_col = 4'b0100; key_on = 1'b1;
      do_reset;
      step(15);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL press_valid_early got %b want 0", valid); end
      step(1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL press_valid got %b want 1", valid); end
      checks++; if (fil !== 4'b0010) begin errors++; $display("FAIL press_fil got %b want 0010", fil); end
      checks++; if (col !== 4'b0100) begin errors++; $display("FAIL press_col got %b want 0100", col); end
      checks++; if (col_out !== 4'b0100) begin errors++; $display("FAIL press_col_out got %b want 0100", col_out); end
      step(4);
      checks++; if (col_out !== 4'b0100) begin errors++; $display("FAIL held_col_out got %b want 0100", col_out); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL held_valid got %b want 1", valid); end
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ack_valid got %b want 0", valid); end
      checks++; if (fil !== 4'b0010) begin errors++; $display("FAIL ack_fil_hold got %b want 0010", fil); end
      checks++; if (col !== 4'b0100) begin errors++; $display("FAIL ack_col_hold got %b want 0100", col); end
      key_on = 1'b0;
      step(9);
      checks++; if (col_out !== 4'b0100) begin errors++; $display("FAIL release_early got %b want 0100", col_out); end
      step(1);
      checks++; if (col_out !== 4'b0010) begin errors++; $display("FAIL release_col_out got %b want 0010", col_out); end
   endtask

   task automatic test_bounce;
      key_row = 4'b0010; key_col = 4'b0100; key_on = 1'b0;
      do_reset;
      for (int k = 0; k < 40; k++) begin
         key_on = (k >= 4 && k < 24) ? (((k - 4) / 3) % 2 == 0) : 1'b0;
         checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bounce_valid k=%0d got %b want 0", k, valid); end
         if (k == 10) begin
            checks++; if (col_out !== 4'b0010) begin errors++; $display("FAIL bounce_col_out got %b want 0010", col_out); end
         end
         step(1);
      end
      key_on = 1'b0;
   endtask

   task automatic test_multi_rows;
      key_row = 4'b1100; key_col = 4'b1000; key_on = 1'b1;
      do_reset;
      step(3);
      checks++; if (col_out !== 4'b1000) begin errors++; $display("FAIL multi_col_out_n3 got %b want 1000", col_out); end
      step(1);
      checks++; if (col_out !== 4'b0100) begin errors++; $display("FAIL multi_col_out_n4 got %b want 0100", col_out); end
      step(12);
      checks++; if (col_out !== 4'b1000) begin errors++; $display("FAIL multi_col_out_n16 got %b want 1000", col_out); end
      step(4);
      checks++; if (col_out !== 4'b0100) begin errors++; $display("FAIL multi_col_out_n20 got %b want 0100", col_out); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL multi_valid got %b want 0", valid); end
      key_on = 1'b0;
   endtask

   task automatic test_press_while_pending;
      key_row = 4'b1000; key_col = 4'b1000; key_on = 1'b1;
      do_reset;
      step(11);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL pend_valid_early got %b want 0", valid); end
      step(1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL pend_valid1 got %b want 1", valid); end
      checks++; if (fil !== 4'b1000) begin errors++; $display("FAIL pend_fil1 got %b want 1000", fil); end
      checks++; if (col !== 4'b1000) begin errors++; $display("FAIL pend_col1 got %b want 1000", col); end
      key_on = 1'b0;
      step(9);
      checks++; if (col_out !== 4'b1000) begin errors++; $display("FAIL pend_held got %b want 1000", col_out); end
      step(1);
      checks++; if (col_out !== 4'b0100) begin errors++; $display("FAIL pend_next_col got %b want 0100", col_out); end
      key_row = 4'b0100; key_col = 4'b0100; key_on = 1'b1;
      step(12);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL pend_valid_kept got %b want 1", valid); end
      checks++; if (fil !== 4'b1000) begin errors++; $display("FAIL pend_fil_kept got %b want 1000", fil); end
      checks++; if (col !== 4'b1000) begin errors++; $display("FAIL pend_col_kept got %b want 1000", col); end
      checks++; if (col_out !== 4'b0100) begin errors++; $display("FAIL pend_frozen got %b want 0100", col_out); end
      key_on = 1'b0;
      step(10);
      checks++; if (col_out !== 4'b0010) begin errors++; $display("FAIL pend_release got %b want 0010", col_out); end
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL pend_ack got %b want 0", valid); end
      key_on = 1'b1;
      step(22);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL pend_second_early got %b want 0", valid); end
      step(1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL pend_second_valid got %b want 1", valid); end
      checks++; if (fil !== 4'b0100) begin errors++; $display("FAIL pend_second_fil got %b want 0100", fil); end
      checks++; if (col !== 4'b0100) begin errors++; $display("FAIL pend_second_col got %b want 0100", col); end
      key_on = 1'b0;
   endtask

   task automatic test_reset_mid;
      key_row = 4'b1000; key_col = 4'b1000; key_on = 1'b1;
      do_reset;
      step(12);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", valid); end
      key_on = 1'b0;
      step(10);
      key_row = 4'b0010; key_col = 4'b0100; key_on = 1'b1;
      step(7);
      checks++; if (col_out !== 4'b0100) begin errors++; $display("FAIL mid_deb_col_out got %b want 0100", col_out); end
      rst_n = 1'b0;
      #1;
      checks++; if (col_out !== 4'b1000) begin errors++; $display("FAIL mid_rst_col_out got %b want 1000", col_out); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", valid); end
      checks++; if (fil !== 4'b0000) begin errors++; $display("FAIL mid_rst_fil got %b want 0000", fil); end
      checks++; if (col !== 4'b0000) begin errors++; $display("FAIL mid_rst_col got %b want 0000", col); end
      step(2);
      rst_n = 1'b1;
      step(15);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_after_early got %b want 0", valid); end
      step(1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL mid_after_valid got %b want 1", valid); end
      checks++; if (fil !== 4'b0010) begin errors++; $display("FAIL mid_after_fil got %b want 0010", fil); end
      checks++; if (col !== 4'b0100) begin errors++; $display("FAIL mid_after_col got %b want 0100", col); end
      key_on = 1'b0;
   endtask

   initial begin
      test_reset;
      test_scan_rotation;
      test_press_ack;
      test_bounce;
      test_multi_rows;
      test_press_while_pending;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
